// File: rtl/universal_shift_reg_if.sv
// Operation request / result bundle for universal_shift_reg.
// master: the requester (drives start, mode, amount, load_data, ser_in).
// slave : the shift register (drives q, busy, done, ser_out).
// WIDTH and AMT_W must match the parameters of the attached universal_shift_reg.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             ser_out;

  modport master (
    output start, mode, amount, load_data, ser_in,
    input  q, busy, done, ser_out
  );

  modport slave (
    input  start, mode, amount, load_data, ser_in,
    output q, busy, done, ser_out
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: load, logical/arithmetic shift, rotate under a two-state IDLE/RUN FSM.
// Latency: start accepted at edge N, result and one-cycle done at edge N+k (k=1 load/no-op/amount 0, else amount).
// Backpressure: none; start is ignored while busy, and a start in the done cycle is accepted back-to-back.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries start/mode/amount/load_data/ser_in
// in and q/busy/done/ser_out out.
// Optional macro USR_BARREL_EN: every operation completes in one step using a barrel shifter/rotator.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic                  clk,
  input logic                  rst,
  universal_shift_reg_if.slave bus
);

  localparam logic [2:0] M_LOAD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_NOP  = 3'b110;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [2:0]       mode_r, mode_n;
  logic [AMT_W-1:0] cnt_r, cnt_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic             ser_out_r, ser_out_n;
  logic             done_r, done_n;
  logic [WIDTH-1:0] res_q;
  logic             res_so;
  logic [2:0]       mode_req;

  // A zero-count shift/rotate and both no-op codes collapse to a single-cycle no-op,
  // so the execute logic never has to special-case amount==0.
  always_comb begin
    mode_req = bus.mode;
    if (bus.mode[2:1] == 2'b11 || (bus.mode != M_LOAD && bus.amount == '0)) begin
      mode_req = M_NOP;
    end
  end

`ifdef USR_BARREL_EN
  logic [AMT_W-1:0] amt_r, amt_n;

  // Whole operation in one step. Vacated bits take the fill value; ser_out is the
  // bit that would have departed on the final single-bit step.
  always_comb begin
    int   a;
    int   r;
    logic fill;
    a      = int'(amt_r);
    r      = a % WIDTH;
    fill   = (mode_r == M_ASR) ? q_r[WIDTH-1] : bus.ser_in;
    res_q  = q_r;
    res_so = ser_out_r;
    case (mode_r)
      M_LOAD: res_q = bus.load_data;
      M_SHL: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= a) res_q[i] = q_r[i-a];
          else        res_q[i] = fill;
        end
        res_so = (a <= WIDTH) ? q_r[WIDTH-a] : fill;
      end
      M_SHR, M_ASR: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i + a < WIDTH) res_q[i] = q_r[i+a];
          else               res_q[i] = fill;
        end
        res_so = (a <= WIDTH) ? q_r[a-1] : fill;
      end
      M_ROL: begin
        for (int i = 0; i < WIDTH; i++) res_q[i] = q_r[(i - r + WIDTH) % WIDTH];
        // The last bit rotated out of the MSB lands in q[0].
        res_so = res_q[0];
      end
      M_ROR: begin
        for (int i = 0; i < WIDTH; i++) res_q[i] = q_r[(i + r) % WIDTH];
        res_so = res_q[WIDTH-1];
      end
      default: ;
    endcase
  end
`else
  // One single-bit step of the latched mode.
  always_comb begin
    res_q  = q_r;
    res_so = ser_out_r;
    case (mode_r)
      M_LOAD: res_q = bus.load_data;
      M_SHL: begin
        res_q  = {q_r[WIDTH-2:0], bus.ser_in};
        res_so = q_r[WIDTH-1];
      end
      M_SHR: begin
        res_q  = {bus.ser_in, q_r[WIDTH-1:1]};
        res_so = q_r[0];
      end
      M_ROL: begin
        res_q  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        res_so = q_r[WIDTH-1];
      end
      M_ROR: begin
        res_q  = {q_r[0], q_r[WIDTH-1:1]};
        res_so = q_r[0];
      end
      M_ASR: begin
        res_q  = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        res_so = q_r[0];
      end
      default: ;
    endcase
  end
`endif

  // Next-state / datapath control.
  always_comb begin
    state_n   = state;
    mode_n    = mode_r;
    cnt_n     = cnt_r;
    q_n       = q_r;
    ser_out_n = ser_out_r;
    done_n    = 1'b0;
`ifdef USR_BARREL_EN
    amt_n     = amt_r;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          mode_n  = mode_req;
`ifdef USR_BARREL_EN
          amt_n   = bus.amount;
          cnt_n   = AMT_W'(1);
`else
          cnt_n   = (mode_req == M_LOAD || mode_req == M_NOP) ? AMT_W'(1) : bus.amount;
`endif
        end
      end
      RUN: begin
        q_n       = res_q;
        ser_out_n = res_so;
        cnt_n     = cnt_r - AMT_W'(1);
        if (cnt_r == AMT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_r    <= M_NOP;
      cnt_r     <= '0;
      q_r       <= '0;
      ser_out_r <= 1'b0;
      done_r    <= 1'b0;
`ifdef USR_BARREL_EN
      amt_r     <= '0;
`endif
    end else begin
      state     <= state_n;
      mode_r    <= mode_n;
      cnt_r     <= cnt_n;
      q_r       <= q_n;
      ser_out_r <= ser_out_n;
      done_r    <= done_n;
`ifdef USR_BARREL_EN
      amt_r     <= amt_n;
`endif
    end
  end

  assign bus.q       = q_r;
  assign bus.ser_out = ser_out_r;
  assign bus.done    = done_r;
  assign bus.busy    = (state == RUN);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8, AMT_W=3).
// Stimulus pushes the hand-computed result of each operation; a negedge monitor pops
// and compares q, ser_out and the number of busy cycles whenever done is seen.
module tb_universal_shift_reg;

  typedef struct {
    logic [7:0] q;
    logic       so;
    int         busy;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  universal_shift_reg_if #(.WIDTH(8), .AMT_W(3)) bus ();

  universal_shift_reg #(.WIDTH(8), .AMT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the completion pulse is the DUT's output event.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done with q=%0h, expected no done", bus.q);
        end else begin
          e = sb.pop_front();
          chk("q", 32'(bus.q), 32'(e.q));
          chk("ser_out", 32'(bus.ser_out), 32'(e.so));
          chk("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called #1 after an edge; returns #1 after the edge that raised done.
  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected done");
    end
  endtask

  task automatic issue(input logic [2:0] m, input logic [2:0] a, input logic [7:0] ld,
                       input logic sin, input logic [7:0] eq, input logic eso, input int eb);
    exp_t e;
    e.q = eq; e.so = eso; e.busy = eb;
    sb.push_back(e);
    bus.mode      = m;
    bus.amount    = a;
    bus.load_data = ld;
    bus.ser_in    = sin;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.mode      = 3'b000;
    bus.amount    = 3'd0;
    bus.load_data = 8'h00;
    bus.ser_in    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_q", 32'(bus.q), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_ser_out", 32'(bus.ser_out), 32'h0);

    // First start shares the cycle in which rst drops.
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef USR_BARREL_EN
    issue(3'b000, 3'd0, 8'h01, 1'b0, 8'h01, 1'b0, 1);
    issue(3'b011, 3'd5, 8'h00, 1'b0, 8'h20, 1'b0, 1);
    issue(3'b001, 3'd3, 8'h00, 1'b1, 8'h07, 1'b1, 1);
    issue(3'b000, 3'd0, 8'h90, 1'b0, 8'h90, 1'b1, 1);
    issue(3'b101, 3'd2, 8'h00, 1'b1, 8'hE4, 1'b0, 1);
    issue(3'b100, 3'd0, 8'h00, 1'b0, 8'hE4, 1'b0, 1);
    issue(3'b010, 3'd7, 8'h00, 1'b0, 8'h01, 1'b1, 1);
`else
    issue(3'b000, 3'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1);
    issue(3'b000, 3'd0, 8'h81, 1'b0, 8'h81, 1'b0, 1);
    issue(3'b001, 3'd3, 8'h00, 1'b1, 8'h0F, 1'b0, 3);
    issue(3'b000, 3'd0, 8'h90, 1'b0, 8'h90, 1'b0, 1);
    issue(3'b101, 3'd2, 8'h00, 1'b1, 8'hE4, 1'b0, 2);
    issue(3'b010, 3'd3, 8'h00, 1'b0, 8'h1C, 1'b1, 3);
    issue(3'b011, 3'd4, 8'h00, 1'b0, 8'hC1, 1'b1, 4);
    issue(3'b100, 3'd0, 8'h00, 1'b0, 8'hC1, 1'b1, 1);
    issue(3'b110, 3'd5, 8'h00, 1'b0, 8'hC1, 1'b1, 1);
    issue(3'b100, 3'd1, 8'h00, 1'b0, 8'hE0, 1'b1, 1);
    issue(3'b001, 3'd7, 8'h00, 1'b1, 8'h7F, 1'b0, 7);
    issue(3'b111, 3'd3, 8'hFF, 1'b0, 8'h7F, 1'b0, 1);
    issue(3'b010, 3'd2, 8'h00, 1'b1, 8'hDF, 1'b1, 2);

    // Start held high: the load request presented while busy must be ignored,
    // then accepted in the done cycle with no idle gap.
    e.q = 8'h7F; e.so = 1'b1; e.busy = 2;
    sb.push_back(e);
    bus.mode   = 3'b011;
    bus.amount = 3'd2;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.mode      = 3'b000;
    bus.load_data = 8'h33;
    e.q = 8'h33; e.so = 1'b1; e.busy = 1;
    sb.push_back(e);
    wait_done();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'h1);
    wait_done();

    // Reset in the middle of a 7-step rotate right: no done pulse may follow.
    issue(3'b000, 3'd0, 8'h01, 1'b0, 8'h01, 1'b1, 1);
    bus.mode   = 3'b100;
    bus.amount = 3'd7;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("abort_mid_q", 32'(bus.q), 32'h20);
    chk("abort_mid_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_q", 32'(bus.q), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    chk("abort_ser_out", 32'(bus.ser_out), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    issue(3'b000, 3'd0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: data register width in bits; SHALL be at least 2.
REQ-002 Parameter AMT_W, default 3: shift-amount field width in bits.
REQ-003 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  Reset; synchronous and active-high.
REQ-005 start  input  1  Operation request; sampled only in IDLE.
REQ-006 mode  input  3  Operation code, latched with start (REQ-012).
REQ-007 amount  input  AMT_W  Shift or rotate count, latched with start.
REQ-008 load_data  input  WIDTH  Parallel load value, sampled on the load execute edge.
REQ-009 ser_in  input  1  Serial fill bit, sampled on each shift edge.
REQ-010 q  output  WIDTH  Register contents, registered; q[0] is the LSB.
REQ-011 busy, done, ser_out  output  1 each  Operation in progress; one-cycle completion pulse; last bit shifted out (registered).

Function
REQ-012 Mode encodings SHALL be:
- 000 load.
- 001 shift left logical; ser_in enters q[0].
- 010 shift right logical; ser_in enters q[WIDTH-1].
- 011 rotate left.
- 100 rotate right.
- 101 arithmetic right; q[WIDTH-1] is replicated.
- 110 and 111 no-op.
REQ-013 FSM states SHALL be IDLE and RUN.
REQ-014 IDLE to RUN on start=1 at edge N; mode and amount latch at edge N; busy=1 from edge N.
REQ-015 Execution length k SHALL be:
- 1 for load and for no-op.
- amount for the shift and rotate modes.
- 1 when amount=0; that single cycle leaves q unchanged.
REQ-016 Edges N+1 .. N+k each SHALL perform one single-bit step of the latched mode.
REQ-017 Load SHALL write q = load_data at edge N+1.
REQ-018 At edge N+k: RUN to IDLE, busy=0, done=1 for exactly one cycle, and q holds the final value.
REQ-019 start SHALL be ignored while busy=1; a start in the done cycle SHALL be accepted (back-to-back).
REQ-020 amount >= WIDTH SHALL still execute amount steps: logical shifts end fully filled; rotates wrap modulo WIDTH.
REQ-021 ser_out SHALL update on each step edge to the departing bit:
- q[WIDTH-1] for left modes.
- q[0] for right modes.
- Unchanged for load and no-op.
REQ-022 q and ser_out SHALL hold their values in IDLE.

Reset
REQ-023 rst=1 at an edge SHALL force q=0, ser_out=0, busy=0, done=0 and state=IDLE.
REQ-024 rst SHALL override start and any operation in progress; an aborted operation produces no done pulse.
REQ-025 The first start SHALL be accepted at the first edge with rst=0.

Configuration
REQ-026 Macro USR_BARREL_EN controls single-cycle barrel shifting.
REQ-027 With USR_BARREL_EN defined:
- k=1 for all modes.
- The full amount-bit shift or rotate completes at edge N+1.
- Vacated bits take ser_in sampled at edge N+1.
- Arithmetic right fills with the old MSB.
- Rotate count is amount mod WIDTH.
- ser_out is the last bit shifted out; it is unchanged when amount=0.
REQ-028 Without USR_BARREL_EN: the multi-cycle behaviour of REQ-015 to REQ-021 applies and no barrel logic is synthesised.

Verification (WIDTH=8, AMT_W=3, USR_BARREL_EN undefined unless stated)
REQ-029 Load: reset, then start with mode=000, load_data=0xA5 -> q=0xA5 one edge later, busy high for 1 cycle, done pulse 1 cycle.
REQ-030 Shift left: q=0x81, mode=001, amount=3, ser_in=1 -> after 3 step edges q=0x0F, ser_out=0, done on the third edge.
REQ-031 Arithmetic right: q=0x90, mode=101, amount=2 -> q=0xE4, busy high for exactly 2 cycles.
REQ-032 Back-to-back and ignored start:
- start held during busy -> ignored.
- start in the done cycle -> accepted; the next operation begins with no idle gap.
REQ-033 Reset mid-operation: rotate right, amount=7, q=0x01, rst=1 after 3 steps -> q=0x00, busy=0, no done pulse.
REQ-034 Barrel (USR_BARREL_EN defined): q=0x01, mode=011, amount=5 -> q=0x20 after one edge, done on that edge.
